// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operand sequencer: state encoding and the
// function codes understood by the downstream ALU.
package alu_seq_pkg;

    // Sequencer states; the encoding is driven straight onto the LEDs.
    typedef enum logic [1:0] {
        ST_ENTER_A  = 2'd0,
        ST_ENTER_B  = 2'd1,
        ST_ENTER_FN = 2'd2,
        ST_HOLD     = 2'd3
    } seq_state_t;

    // ALU function-select codes (6 and 7 fall through to the ALU default).
    localparam logic [2:0] FN_RIPPLE      = 3'd0;
    localparam logic [2:0] FN_ADD         = 3'd1;
    localparam logic [2:0] FN_NAND_XNOR   = 3'd2;
    localparam logic [2:0] FN_OR_ANY      = 3'd3;
    localparam logic [2:0] FN_ONEHOT_PAIR = 3'd4;
    localparam logic [2:0] FN_CONCAT_INV  = 3'd5;

endpackage

// File: rtl/alu_operand_sequencer_key_edge.sv
// key_edge: conditions one active-low push-button into a single-cycle press
// strobe. Two-flop synchronizer, optional debounce filter (enabled by
// ALU_SEQ_DEBOUNCE_EN), then a registered previous-level compare.
// A key that is already held when reset is released never produces a strobe:
// the detector only arms after it has seen the key released.
module key_edge #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clock,
    input  logic resetn,
    input  logic key_n,
    output logic press
);

    logic       sync1;
    logic       sync2;
    logic       level;
    logic       prev;
    logic       armed;
    logic [1:0] fill;

    // Two-flop synchronizer; resets to the released level.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

`ifdef ALU_SEQ_DEBOUNCE_EN
    logic [15:0] count;

    // Debounce: accept a new level only after it has persisted for
    // DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            level <= 1'b1;
            count <= '0;
        end else if (sync2 == level) begin
            count <= '0;
        end else if (count >= DEBOUNCE_CYCLES - 16'd1) begin
            level <= sync2;
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end
`else
    logic unused_debounce;
    assign unused_debounce = ^DEBOUNCE_CYCLES;
    assign level = sync2;
`endif

    // Arm once the synchronizer holds real samples and shows the key released.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fill  <= 2'd0;
            armed <= 1'b0;
        end else begin
            if (fill != 2'd2) begin
                fill <= fill + 2'd1;
            end
            if (fill == 2'd2 && sync2) begin
                armed <= 1'b1;
            end
        end
    end

    // Falling-edge detect on the conditioned level, registered strobe.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            prev  <= 1'b1;
            press <= 1'b0;
        end else begin
            prev  <= level;
            press <= armed & prev & ~level;
        end
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: front-panel sequencer that collects operand A,
// operand B and the ALU function code from two push-buttons and the digit
// switches, then holds the validated set for the ALU.
// Optional build macro: ALU_SEQ_DEBOUNCE_EN (adds key debounce filtering).
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int          DIGITS          = 1,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    localparam int         W               = 4 * DIGITS
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic [3:0]   digit_in,
    input  logic         load_n,
    input  logic         adv_n,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic [2:0]   fn_sel,
    output logic [1:0]   state,
    output logic         valid,
    output logic         valid_pulse
);

    logic         load;
    logic         adv;
    seq_state_t   state_q;
    seq_state_t   state_d;
    logic [W-1:0] op_a_d;
    logic [W-1:0] op_b_d;
    logic [2:0]   fn_d;
    logic         pulse_d;
    logic [W-1:0] shift_a;
    logic [W-1:0] shift_b;

    key_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
        .clock  (clock),
        .resetn (resetn),
        .key_n  (load_n),
        .press  (load)
    );

    key_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_adv (
        .clock  (clock),
        .resetn (resetn),
        .key_n  (adv_n),
        .press  (adv)
    );

    // New digit enters at the least-significant nibble.
    if (DIGITS == 1) begin : g_single
        assign shift_a = digit_in;
        assign shift_b = digit_in;
    end else begin : g_multi
        assign shift_a = {op_a[W-5:0], digit_in};
        assign shift_b = {op_b[W-5:0], digit_in};
    end

    // Next-state and register updates; a load lands in the current state's
    // register even when the same strobe cycle also advances the state.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a;
        op_b_d  = op_b;
        fn_d    = fn_sel;
        pulse_d = 1'b0;
        case (state_q)
            ST_ENTER_A: begin
                if (load) op_a_d = shift_a;
                if (adv)  state_d = ST_ENTER_B;
            end
            ST_ENTER_B: begin
                if (load) op_b_d = shift_b;
                if (adv)  state_d = ST_ENTER_FN;
            end
            ST_ENTER_FN: begin
                if (load) fn_d = digit_in[2:0];
                if (adv) begin
                    state_d = ST_HOLD;
                    pulse_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (adv) begin
                    state_d = ST_ENTER_A;
                    op_a_d  = '0;
                    op_b_d  = '0;
                    fn_d    = 3'd0;
                end
            end
            default: state_d = ST_ENTER_A;
        endcase
    end

    // State and operand registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_ENTER_A;
            op_a        <= '0;
            op_b        <= '0;
            fn_sel      <= 3'd0;
            valid_pulse <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a        <= op_a_d;
            op_b        <= op_b_d;
            fn_sel      <= fn_d;
            valid_pulse <= pulse_d;
        end
    end

    assign state = state_q;
    assign valid = (state_q == ST_HOLD);

endmodule
